// File: rtl/iter_alu.sv
// iter_alu: execute-stage ALU with valid/ready handshake and one-bit-per-cycle shifter.
// Define ITER_ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module iter_alu #(
    parameter int DWIDTH = 32,
    parameter int SHW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic              busy
);
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_n;
    logic              out_valid_n, accept, iter_start;
    logic [DWIDTH-1:0] result_n, work, work_n, step;
    logic [SHW-1:0]    cnt, cnt_n;
    logic [3:0]        sop, sop_n;

    function automatic logic [DWIDTH-1:0] alu_fn(input logic [3:0] op, input logic [DWIDTH-1:0] x, input logic [DWIDTH-1:0] y);
        case (op)
            ALU_ADD:    return x + y;
            ALU_SUB:    return x - y;
            ALU_AND:    return x & y;
            ALU_OR:     return x | y;
            ALU_XOR:    return x ^ y;
            ALU_SLT:    return {{(DWIDTH-1){1'b0}}, $signed(x) < $signed(y)};
            ALU_SLTU:   return {{(DWIDTH-1){1'b0}}, x < y};
            ALU_SLL:    return x << y[SHW-1:0];
            ALU_SRL:    return x >> y[SHW-1:0];
            ALU_SRA:    return DWIDTH'($signed(x) >>> y[SHW-1:0]);
            ALU_COPY_B: return y;
            default:    return '0;
        endcase
    endfunction

    assign in_ready = (state == IDLE) && !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign step     = sop == ALU_SLL ? {work[DWIDTH-2:0], 1'b0} :
                      sop == ALU_SRA ? {work[DWIDTH-1], work[DWIDTH-1:1]} :
                                       {1'b0, work[DWIDTH-1:1]};

`ifdef ITER_ALU_FAST_SHIFT_EN
    assign iter_start = 1'b0;
    assign busy       = 1'b0;
`else
    // a zero shift amount needs no iteration and takes the single-cycle path
    assign iter_start = (alu_op == ALU_SLL || alu_op == ALU_SRL || alu_op == ALU_SRA) && |b[SHW-1:0];
    assign busy       = state == SHIFT;
`endif

    always_comb begin
        state_n     = state;
        out_valid_n = out_valid;
        result_n    = result;
        work_n      = work;
        cnt_n       = cnt;
        sop_n       = sop;
        if (state == SHIFT) begin
            work_n = step;
            cnt_n  = cnt - 1'b1;
            if (cnt == SHW'(1)) begin
                state_n     = IDLE;
                out_valid_n = 1'b1;
                result_n    = step;
            end
        end else if (accept) begin
            if (iter_start) begin
                state_n     = SHIFT;
                out_valid_n = 1'b0;
                work_n      = a;
                cnt_n       = b[SHW-1:0];
                sop_n       = alu_op;
            end else begin
                out_valid_n = 1'b1;
                result_n    = alu_fn(alu_op, a, b);
            end
        end else if (out_ready) begin
            out_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            work      <= '0;
            cnt       <= '0;
            sop       <= ALU_ADD;
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            result    <= result_n;
            work      <= work_n;
            cnt       <= cnt_n;
            sop       <= sop_n;
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: randomized and directed checks of iter_alu against an arithmetic reference model.
module tb_iter_alu;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]  alu_op;
    logic [31:0] a, b, result;
    int          n_cmp = 0;
    int          n_err = 0;

    iter_alu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        logic [31:0] r;
        sh = y % 32;
        r  = x;
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6: return (x < y) ? 32'd1 : 32'd0;
            4'd7: return x * (32'd1 << sh);
            4'd8: begin
                for (int i = 0; i < sh; i++) r = {x[31], r[31:1]};
                return r;
            end
            4'd9: return x / (33'd1 << sh);
            4'd10: return y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
`ifdef ITER_ALU_FAST_SHIFT_EN
        return 1;
`else
        return (op inside {4'd7, 4'd8, 4'd9}) ? int'(y % 32) + 1 : 1;
`endif
    endfunction

    // Issues one op (out_ready high), waits for its result and checks value, latency and shift status.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] exp;
        int          lat, elat, guard;
        exp   = ref_alu(op, x, y);
        elat  = ref_lat(op, y);
        guard = 0;
        out_ready = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        alu_op = op; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_rdy_shift"}, 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_res"}, result, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x, y, held;
        logic [3:0]  op;
        int          k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_op = 4'd0; a = '0; b = '0;
        tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        issue("add", 4'd0, 32'h7FFFFFFF, 32'd1);
        issue("slt", 4'd5, 32'hFFFFFFFF, 32'd1);
        issue("sltu", 4'd6, 32'hFFFFFFFF, 32'd1);
        issue("copyb", 4'd10, 32'h12345678, 32'hDEADBEEF);
        issue("xxx", 4'd15, 32'h12345678, 32'h9ABCDEF0);
        issue("undef13", 4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue("sra4", 4'd8, 32'h80000010, 32'h24);
        chk("sra4_val", result, 32'hF8000001);
        issue("srl4", 4'd9, 32'h80000010, 32'h24);
        chk("srl4_val", result, 32'h08000001);
        issue("sll0", 4'd7, 32'hCAFEF00D, 32'h40);
        issue("sll31", 4'd7, 32'd1, 32'd31);
        chk("sll31_val", result, 32'h80000000);

        issue("bp_add", 4'd0, 32'd100, 32'd23);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_hold", result, 32'd123);
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; alu_op = 4'd4; a = 32'hF0F0F0F0; b = 32'hFFFF0000; in_valid = 1'b1;
        #1;
        chk("b2b_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_res", result, 32'h0F0FF0F0);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        alu_op = 4'd7; a = 32'h00000ABC; b = 32'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifndef ITER_ALU_FAST_SHIFT_EN
            chk("mid_busy", 32'(busy), 32'd1);
`endif
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("mid_rst_nores", 32'(out_valid), 32'd0);
        end

        for (int n = 0; n < 200; n++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            issue("rnd", op, x, y);
            held = result;
            k = $urandom_range(0, 3);
            out_ready = 1'b0;
            for (int i = 0; i < k; i++) begin
                tick();
                chk("rnd_hold", result, held);
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU decoder, together with the two 32-bit operands from the datapath.
- Produces a 32-bit registered result through a valid/ready handshake on both sides.
- Non-shift operations complete in one cycle; shifts are iterative, one bit per cycle, to save area on the FPGA target.
- Sits between decode/operand-select and the writeback/memory-address path.

Parameters:
- DWIDTH, 32, operand and result width.
- SHW, 5, width of shift amount, log2(DWIDTH).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands and op valid
- in_ready  output  1  block can accept a new operation
- alu_op  input  4  operation, encoded per ALUop.vh macros
- a  input  DWIDTH  operand A (rs1 / PC)
- b  input  DWIDTH  operand B (rs2 / immediate)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  DWIDTH  registered result
- busy  output  1  high while a shift is iterating

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
  - On rst: state=IDLE, out_valid=0, result=0, busy=0, shift counter=0.
  - in_ready is forced 0 during the rst cycle.
- Accept: in_ready = (state==IDLE) && !rst && (!out_valid || out_ready). An op is accepted when in_valid && in_ready.
- States:
  - IDLE: waiting for an op.
  - SHIFT: iterating a shift.
  - IDLE with out_valid held: output waiting to be taken.
- Single-cycle ops, result registered on the accept edge, out_valid=1 the next cycle (latency 1):
  - ALU_ADD: a+b mod 2^32.
  - ALU_SUB: a-b mod 2^32.
  - ALU_AND, ALU_OR, ALU_XOR: bitwise.
  - ALU_SLT: signed a<b gives 1, else 0.
  - ALU_SLTU: unsigned compare, same 1/0 result.
  - ALU_COPY_B: b.
  - ALU_XXX or any unlisted code: result 0, still completes in 1 cycle.
- Shift ops (ALU_SLL, ALU_SRL, ALU_SRA):
  - On accept: latch a into a working register, latch b[4:0] into the counter, latch the op. b[31:5] is ignored.
  - If shamt==0: behaves as a single-cycle op, result=a, latency 1.
  - Else: enter SHIFT with busy=1. Each cycle shift the working register by 1 (SRA replicates bit 31) and decrement the counter.
  - When the counter reaches 0, the working register is copied to result, out_valid=1, state returns to IDLE, busy=0.
  - Latency from accept to out_valid = shamt+1 cycles (shamt 31 gives 32 cycles).
- Output hold: result and out_valid stay stable while out_valid && !out_ready. out_valid drops the cycle after out_ready is seen, unless a new op is accepted on that same edge.
- Simultaneous events: out_ready && in_valid in the same cycle (state IDLE, out_valid=1) is allowed.
  - Old result retires.
  - The new op is accepted.
  - For a single-cycle op, result/out_valid update on the same edge, giving back-to-back throughput of 1 op/cycle.
- in_valid is ignored while state==SHIFT. Operands need not be held after acceptance.
- rst mid-shift: abandons the operation immediately. No result is produced and the state returns to IDLE.
- No other stall or flush input. A pipeline flush is implemented by asserting rst.

Optional Feature:
- Macro: ITER_ALU_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. All ops have latency 1, the SHIFT state is never entered, and busy is tied 0.
- Undefined: the iterative shifter described above.
- Handshake, reset values, and results are otherwise identical in both builds.

Test Plan:
- ADD, single op: rst for 2 cycles, then a=0x7FFFFFFF, b=1, in_valid=1, out_ready=1 -> out_valid one cycle later, result=0x80000000; out_valid=0 and result=0 during and just after rst.
- SLT vs SLTU: a=0xFFFFFFFF, b=1 -> SLT gives 0x1; SLTU gives 0x0. COPY_B with b=0xDEADBEEF gives 0xDEADBEEF. Undefined op code gives 0.
- SRA iterative: a=0x80000010, b=0x24 (shamt=4) -> busy=1 for 4 cycles, in_ready=0 throughout, out_valid 5 cycles after accept, result=0xF8000001. SRL of the same operands gives 0x08000001. shamt=0 gives a, latency 1.
- Backpressure: out_ready=0 after an ADD result -> result held stable for 10 cycles, in_ready=0. Raise out_ready together with in_valid (XOR a=0xF0F0F0F0, b=0xFFFF0000) -> next cycle result=0x0F0FF0F0, no bubble.
- Reset mid-shift: SLL with shamt=20, assert rst on the 5th SHIFT cycle -> next cycle state IDLE, out_valid=0, busy=0, and no result ever appears for that op.
- Build with ITER_ALU_FAST_SHIFT_EN: SLL a=1, b=31 -> result=0x80000000 one cycle after accept, busy never asserted.
